// File: rtl/alu_issue_pkg.sv
// Shared constants for the ALU issue controller: ALU ctrl codes, ALUOp and
// funct encodings, and the issue FSM state type.
package alu_issue_pkg;

  // ALU control codes; CTRL_BYPASS makes the ALU return 0.
  localparam logic [3:0] CTRL_AND    = 4'd0;
  localparam logic [3:0] CTRL_OR     = 4'd1;
  localparam logic [3:0] CTRL_ADD    = 4'd2;
  localparam logic [3:0] CTRL_SUB    = 4'd6;
  localparam logic [3:0] CTRL_SLT    = 4'd7;
  localparam logic [3:0] CTRL_NOR    = 4'd12;
  localparam logic [3:0] CTRL_BYPASS = 4'd15;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_RTYPE = 3'b010;
  localparam logic [2:0] ALUOP_SLT   = 3'b011;
  localparam logic [2:0] ALUOP_OR    = 3'b100;

  localparam logic [5:0] FUNCT_SLL = 6'h00;
  localparam logic [5:0] FUNCT_SRL = 6'h02;
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_NOR = 6'h27;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALUOp/funct decode into the 4-bit ALU ctrl code plus shift and
// illegal flags. Shift functs are legal only with ALU_ISSUE_SHIFT_EN defined.
module alu_op_decode
  import alu_issue_pkg::*;
(
  input  logic [2:0] aluop,
  input  logic [5:0] funct,
  output logic [3:0] ctrl,
  output logic       is_shift,
  output logic       illegal
);

  always_comb begin
    ctrl     = CTRL_BYPASS;
    is_shift = 1'b0;
    illegal  = 1'b0;
    case (aluop)
      ALUOP_ADD: ctrl = CTRL_ADD;
      ALUOP_SUB: ctrl = CTRL_SUB;
      ALUOP_SLT: ctrl = CTRL_SLT;
      ALUOP_OR:  ctrl = CTRL_OR;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD: ctrl = CTRL_ADD;
          FUNCT_SUB: ctrl = CTRL_SUB;
          FUNCT_AND: ctrl = CTRL_AND;
          FUNCT_OR:  ctrl = CTRL_OR;
          FUNCT_NOR: ctrl = CTRL_NOR;
          FUNCT_SLT: ctrl = CTRL_SLT;
`ifdef ALU_ISSUE_SHIFT_EN
          // Shifts are computed in the issue block; the ALU sees the bypass code.
          FUNCT_SLL, FUNCT_SRL: is_shift = 1'b1;
`endif
          default:   illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: accepts one request, holds ALU inputs for SETTLE_CYC
// cycles, registers the response. Optional local shifts via ALU_ISSUE_SHIFT_EN.
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int SETTLE_CYC = 1,
  parameter int DW         = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic [2:0]    aluop_i,
  input  logic [5:0]    funct_i,
  input  logic [4:0]    shamt_i,
  input  logic [DW-1:0] src1_i,
  input  logic [DW-1:0] src2_i,
  output logic [DW-1:0] alu_src1_o,
  output logic [DW-1:0] alu_src2_o,
  output logic [3:0]    alu_ctrl_o,
  input  logic [DW-1:0] alu_result_i,
  input  logic          alu_zero_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [DW-1:0] rsp_result_o,
  output logic          rsp_zero_o,
  output logic          rsp_err_o,
  output logic [1:0]    state_o
);

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYC - 1);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; req accepted only in IDLE, rsp held stable in RESP until taken.

  state_t        state, state_n;
  logic [3:0]    cnt;
  logic          rst_done_q;
  logic [DW-1:0] src1_q, src2_q;
  logic [3:0]    ctrl_q;
  logic          err_q;
  logic [DW-1:0] rsp_result_q;
  logic          rsp_zero_q;
  logic [3:0]    dec_ctrl;
  logic          dec_is_shift;
  logic          dec_illegal;
  logic          accept;
  logic          capture;
  logic [DW-1:0] cap_result;
  logic          cap_zero;

  alu_op_decode u_decode (
    .aluop    (aluop_i),
    .funct    (funct_i),
    .ctrl     (dec_ctrl),
    .is_shift (dec_is_shift),
    .illegal  (dec_illegal)
  );

  assign req_ready_o  = (state == ST_IDLE) && rst_done_q;
  assign accept       = req_valid_i && req_ready_o;
  assign capture      = (state == ST_EXEC) && (cnt == 4'd0);
  assign rsp_valid_o  = (state == ST_RESP);
  assign alu_src1_o   = src1_q;
  assign alu_src2_o   = src2_q;
  assign alu_ctrl_o   = ctrl_q;
  assign rsp_result_o = rsp_result_q;
  assign rsp_zero_o   = rsp_zero_q;
  assign rsp_err_o    = err_q & rsp_valid_o;
  assign state_o      = state;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (accept)      state_n = ST_EXEC;
      ST_EXEC: if (cnt == 4'd0) state_n = ST_RESP;
      ST_RESP: if (rsp_ready_i) state_n = ST_IDLE;
      default:                  state_n = ST_IDLE;
    endcase
  end

  // Keeps req_ready_o low until the first edge after reset release.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) rst_done_q <= 1'b0;
    else        rst_done_q <= 1'b1;
  end

`ifdef ALU_ISSUE_SHIFT_EN
  logic [4:0]    shamt_q;
  logic          shift_q;
  logic          shr_q;
  logic [DW-1:0] shift_res;

  assign shift_res = shr_q ? (src2_q >> shamt_q) : (src2_q << shamt_q);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      shamt_q <= '0;
      shift_q <= 1'b0;
      shr_q   <= 1'b0;
    end else if (accept) begin
      shamt_q <= shamt_i;
      shift_q <= dec_is_shift;
      shr_q   <= (funct_i == FUNCT_SRL);
    end
  end
`else
  logic unused_shift;
  assign unused_shift = ^{shamt_i, dec_is_shift};
`endif

  always_comb begin
    cap_result = alu_result_i;
    cap_zero   = alu_zero_i;
    if (err_q) begin
      cap_result = '0;
      cap_zero   = 1'b1;
    end
`ifdef ALU_ISSUE_SHIFT_EN
    else if (shift_q) begin
      cap_result = shift_res;
      cap_zero   = (shift_res == '0);
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt          <= 4'd0;
      src1_q       <= '0;
      src2_q       <= '0;
      ctrl_q       <= 4'd0;
      err_q        <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
    end else begin
      if (accept) begin
        src1_q <= src1_i;
        src2_q <= src2_i;
        ctrl_q <= dec_ctrl;
        err_q  <= dec_illegal;
        cnt    <= CNT_LOAD;
      end else if (state == ST_EXEC && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (capture) begin
        rsp_result_q <= cap_result;
        rsp_zero_q   <= cap_zero;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed plus randomized bench for alu_issue_ctrl with a behavioural ALU and
// a spec-level reference model for ctrl code, result, zero and error.
module tb_alu_issue_ctrl;

  localparam int DW     = 32;
  localparam int SETTLE = 3;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic [2:0]    aluop_i = '0;
  logic [5:0]    funct_i = '0;
  logic [4:0]    shamt_i = '0;
  logic [DW-1:0] src1_i = '0;
  logic [DW-1:0] src2_i = '0;
  logic [DW-1:0] alu_src1_o, alu_src2_o;
  logic [3:0]    alu_ctrl_o;
  logic [DW-1:0] alu_result_i;
  logic          alu_zero_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i = 1'b0;
  logic [DW-1:0] rsp_result_o;
  logic          rsp_zero_o;
  logic          rsp_err_o;
  logic [1:0]    state_o;

  int checks = 0;
  int errors = 0;

  alu_issue_ctrl #(.SETTLE_CYC(SETTLE), .DW(DW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .aluop_i(aluop_i), .funct_i(funct_i), .shamt_i(shamt_i),
    .src1_i(src1_i), .src2_i(src2_i),
    .alu_src1_o(alu_src1_o), .alu_src2_o(alu_src2_o), .alu_ctrl_o(alu_ctrl_o),
    .alu_result_i(alu_result_i), .alu_zero_i(alu_zero_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_result_o(rsp_result_o), .rsp_zero_o(rsp_zero_o), .rsp_err_o(rsp_err_o),
    .state_o(state_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  // behavioural ALU attached to the issue outputs
  always_comb begin
    case (alu_ctrl_o)
      4'd0:    alu_result_i = alu_src1_o & alu_src2_o;
      4'd1:    alu_result_i = alu_src1_o | alu_src2_o;
      4'd2:    alu_result_i = alu_src1_o + alu_src2_o;
      4'd6:    alu_result_i = alu_src1_o - alu_src2_o;
      4'd7:    alu_result_i = ($signed(alu_src1_o) < $signed(alu_src2_o)) ? 32'd1 : 32'd0;
      4'd12:   alu_result_i = ~(alu_src1_o | alu_src2_o);
      default: alu_result_i = '0;
    endcase
    alu_zero_i = (alu_result_i == '0);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: operation named by aluop/funct, evaluated with plain arithmetic.
  function automatic void ref_model(input logic [2:0] op, input logic [5:0] f,
                                    input logic [4:0] sh, input logic [31:0] a,
                                    input logic [31:0] b, output logic [3:0] ctrl,
                                    output logic [31:0] res, output logic zero,
                                    output logic err);
    err = 1'b0; ctrl = 4'd15; res = '0;
    if (op == 3'd0)      begin ctrl = 4'd2; res = a + b; end
    else if (op == 3'd1) begin ctrl = 4'd6; res = a - b; end
    else if (op == 3'd3) begin ctrl = 4'd7; res = ($signed(a) < $signed(b)) ? 1 : 0; end
    else if (op == 3'd4) begin ctrl = 4'd1; res = a | b; end
    else if (op == 3'd2) begin
      if (f == 6'h20)      begin ctrl = 4'd2;  res = a + b; end
      else if (f == 6'h22) begin ctrl = 4'd6;  res = a - b; end
      else if (f == 6'h24) begin ctrl = 4'd0;  res = a & b; end
      else if (f == 6'h25) begin ctrl = 4'd1;  res = a | b; end
      else if (f == 6'h27) begin ctrl = 4'd12; res = ~(a | b); end
      else if (f == 6'h2A) begin ctrl = 4'd7;  res = ($signed(a) < $signed(b)) ? 1 : 0; end
`ifdef ALU_ISSUE_SHIFT_EN
      else if (f == 6'h00) res = b << sh;
      else if (f == 6'h02) res = b >> sh;
`endif
      else err = 1'b1;
    end else err = 1'b1;
    zero = err ? 1'b1 : (res == 0);
  endfunction

  task automatic drive_garbage();
    req_valid_i = 1'($urandom_range(0, 1));
    aluop_i = 3'($urandom); funct_i = 6'($urandom); shamt_i = 5'($urandom);
    src1_i = $urandom; src2_i = $urandom;
  endtask

  // driver: one full transaction with rsp_ready_i held low for 'hold' cycles
  task automatic run_op(input logic [2:0] op, input logic [5:0] f, input logic [4:0] sh,
                        input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [3:0] e_ctrl; logic [31:0] e_res; logic e_zero, e_err;
    logic [31:0] exp_q[$];
    int guard, lat;
    ref_model(op, f, sh, a, b, e_ctrl, e_res, e_zero, e_err);
    exp_q.push_back(e_res);
    guard = 0;
    while (!req_ready_o && guard < 100) begin @(negedge clk_i); guard++; end
    chk("req_ready_idle", req_ready_o, 1);
    req_valid_i = 1'b1; aluop_i = op; funct_i = f; shamt_i = sh; src1_i = a; src2_i = b;
    @(posedge clk_i); lat = 1;
    @(negedge clk_i);
    chk("alu_ctrl", alu_ctrl_o, e_ctrl);
    chk("req_ready_busy", req_ready_o, 0);
    while (!rsp_valid_o && lat < 64) begin
      chk("alu_src1_hold", alu_src1_o, a);
      chk("alu_src2_hold", alu_src2_o, b);
      drive_garbage();
      @(posedge clk_i); lat++;
      @(negedge clk_i);
    end
    chk("latency", lat, SETTLE + 1);
    for (int i = 0; i < hold; i++) begin
      chk("bp_valid", rsp_valid_o, 1);
      chk("bp_result", rsp_result_o, exp_q[0]);
      chk("bp_req_ready", req_ready_o, 0);
      drive_garbage();
      @(negedge clk_i);
    end
    chk("rsp_valid", rsp_valid_o, 1);
    chk("rsp_result", rsp_result_o, exp_q.pop_front());
    chk("rsp_zero", rsp_zero_o, e_zero);
    chk("rsp_err", rsp_err_o, e_err);
    chk("alu_ctrl_resp", alu_ctrl_o, e_ctrl);
    rsp_ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    rsp_ready_i = 1'b0; req_valid_i = 1'b0;
    chk("rsp_done", rsp_valid_o, 0);
    chk("req_ready_after", req_ready_o, 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, rsp_valid_o, 0);
    chk({tag, "_ready"}, req_ready_o, 0);
    chk({tag, "_result"}, rsp_result_o, 0);
    chk({tag, "_zero"}, rsp_zero_o, 0);
    chk({tag, "_err"}, rsp_err_o, 0);
    chk({tag, "_src1"}, alu_src1_o, 0);
    chk({tag, "_src2"}, alu_src2_o, 0);
    chk({tag, "_ctrl"}, alu_ctrl_o, 0);
  endtask

  logic [5:0] funct_tab [9] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00, 6'h02, 6'h3F};

  initial begin
    logic [2:0] op; logic [31:0] a, b; int r;
    // reset
    repeat (3) @(negedge clk_i);
    chk_all_zero("reset");
    rst_i = 1'b1;
    #1 chk("ready_at_release", req_ready_o, 0);
    @(negedge clk_i);
    chk("ready_after_release", req_ready_o, 1);

    // directed steps
    run_op(3'b000, 6'h00, 5'd0, 32'd5, 32'd7, 0);
    run_op(3'b001, 6'h00, 5'd0, 32'h1234, 32'h1234, 1);
    run_op(3'b010, 6'h2A, 5'd0, 32'hFFFF_FFFD, 32'd2, 0);
    run_op(3'b010, 6'h27, 5'd0, 32'd0, 32'd0, 0);
    run_op(3'b011, 6'h00, 5'd0, 32'd9, 32'hFFFF_FFFF, 5);
    run_op(3'b100, 6'h00, 5'd0, 32'hF0F0_0000, 32'h0000_0F0F, 0);
    run_op(3'b010, 6'h3F, 5'd0, 32'd3, 32'd4, 2);
    run_op(3'b111, 6'h20, 5'd0, 32'd3, 32'd4, 0);
    run_op(3'b010, 6'h00, 5'd4, 32'd0, 32'd1, 0);
    run_op(3'b010, 6'h02, 5'd3, 32'd0, 32'h8000_0000, 0);

    // reset in the middle of EXEC
    while (!req_ready_o) @(negedge clk_i);
    req_valid_i = 1'b1; aluop_i = 3'b000; src1_i = 32'd1; src2_i = 32'd2;
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    rst_i = 1'b0;
    #1 chk_all_zero("mid_exec_reset");
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    for (int i = 0; i < SETTLE + 3; i++) begin
      @(negedge clk_i);
      chk("no_rsp_after_reset", rsp_valid_o, 0);
    end
    run_op(3'b010, 6'h20, 5'd0, 32'd100, 32'd23, 1);

    // randomized operations
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 11);
      op = (r < 6) ? 3'b010 : (r < 11) ? 3'(r - 6) : 3'($urandom_range(5, 7));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      run_op(op, funct_tab[$urandom_range(0, 8)], 5'($urandom), a, b, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
